// File: rtl/tt_sweep_capture_if.sv
// rtl/tt_sweep_capture_if.sv - sweep/capture handshake and result bundle (optional TT_MISMATCH_LOG_EN signals)
interface tt_sweep_capture_if;
   logic        start;
   logic        y_in;
   logic [4:0]  x_out;
   logic        busy;
   logic        done;
   logic [31:0] table_out;
   logic [5:0]  ones_count;
   logic        match;
`ifdef TT_MISMATCH_LOG_EN
   logic        mismatch_valid;
   logic [4:0]  mismatch_idx;
`endif

   modport master (
      input  start, y_in,
      output x_out, busy, done, table_out, ones_count, match
`ifdef TT_MISMATCH_LOG_EN
      , output mismatch_valid, mismatch_idx
`endif
   );

   modport slave (
      output start, y_in,
      input  x_out, busy, done, table_out, ones_count, match
`ifdef TT_MISMATCH_LOG_EN
      , input mismatch_valid, mismatch_idx
`endif
   );
endinterface

// File: rtl/tt_sweep_capture.sv
// rtl/tt_sweep_capture.sv - exhaustive 32-vector sweep and truth-table capture (optional TT_MISMATCH_LOG_EN)
module tt_sweep_capture #(
   parameter int          SETTLE_CYCLES = 2,
   parameter logic [31:0] EXPECTED      = 32'h0000_0000
) (
   input  logic               clk,
   input  logic               rst,
   tt_sweep_capture_if.master sw
);
   typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;

   localparam logic [3:0] SETTLE_LAST = 4'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);
   localparam state_t     VEC_STATE   = (SETTLE_CYCLES > 0) ? SETTLE : SAMPLE;

   state_t      r_state, w_state;
   logic [3:0]  r_cnt, w_cnt;
   logic [4:0]  r_x, w_x;
   logic        r_busy, w_busy;
   logic        r_done, w_done;
   logic [31:0] r_table, w_table;
   logic [5:0]  r_ones, w_ones;
   logic        r_match, w_match;
`ifdef TT_MISMATCH_LOG_EN
   logic        r_mm_valid, w_mm_valid;
   logic [4:0]  r_mm_idx, w_mm_idx;
`endif

   always_comb begin
      w_state = r_state;
      w_cnt   = r_cnt;
      w_x     = r_x;
      w_busy  = r_busy;
      w_done  = r_done;
      w_table = r_table;
      w_ones  = r_ones;
      w_match = r_match;
`ifdef TT_MISMATCH_LOG_EN
      w_mm_valid = r_mm_valid;
      w_mm_idx   = r_mm_idx;
`endif
      case (r_state)
         IDLE, DONE: begin
            if (sw.start) begin
               w_state = VEC_STATE;
               w_cnt   = 4'd0;
               w_x     = 5'd0;
               w_busy  = 1'b1;
               w_done  = 1'b0;
               w_table = 32'd0;
               w_ones  = 6'd0;
               w_match = 1'b0;
`ifdef TT_MISMATCH_LOG_EN
               w_mm_valid = 1'b0;
               w_mm_idx   = 5'd0;
`endif
            end
         end
         SETTLE: begin
            if (r_cnt == SETTLE_LAST) begin
               w_cnt   = 4'd0;
               w_state = SAMPLE;
            end else begin
               w_cnt = r_cnt + 4'd1;
            end
         end
         SAMPLE: begin
            w_table[r_x] = sw.y_in;
            w_ones       = r_ones + {5'd0, sw.y_in};
`ifdef TT_MISMATCH_LOG_EN
            if ((sw.y_in != EXPECTED[r_x]) && !r_mm_valid) begin
               w_mm_valid = 1'b1;
               w_mm_idx   = r_x;
            end
`endif
            // match compares the table including the bit written on this cycle
            if (r_x == 5'd31) begin
               w_state = DONE;
               w_busy  = 1'b0;
               w_done  = 1'b1;
               w_match = (w_table == EXPECTED);
            end else begin
               w_x     = r_x + 5'd1;
               w_cnt   = 4'd0;
               w_state = VEC_STATE;
            end
         end
         default: w_state = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_cnt   <= 4'd0;
         r_x     <= 5'd0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_table <= 32'd0;
         r_ones  <= 6'd0;
         r_match <= 1'b0;
`ifdef TT_MISMATCH_LOG_EN
         r_mm_valid <= 1'b0;
         r_mm_idx   <= 5'd0;
`endif
      end else begin
         r_state <= w_state;
         r_cnt   <= w_cnt;
         r_x     <= w_x;
         r_busy  <= w_busy;
         r_done  <= w_done;
         r_table <= w_table;
         r_ones  <= w_ones;
         r_match <= w_match;
`ifdef TT_MISMATCH_LOG_EN
         r_mm_valid <= w_mm_valid;
         r_mm_idx   <= w_mm_idx;
`endif
      end
   end

   assign sw.x_out      = r_x;
   assign sw.busy       = r_busy;
   assign sw.done       = r_done;
   assign sw.table_out  = r_table;
   assign sw.ones_count = r_ones;
   assign sw.match      = r_match;
`ifdef TT_MISMATCH_LOG_EN
   assign sw.mismatch_valid = r_mm_valid;
   assign sw.mismatch_idx   = r_mm_idx;
`endif
endmodule

// File: tb/tb_tt_sweep_capture.sv
// tb/tb_tt_sweep_capture.sv - directed bench for tt_sweep_capture (TT_MISMATCH_LOG_EN aware)
module tb_tt_sweep_capture;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_pass = 0;
   int   n_total = 0;
   int   mode_a = 0;
   int   cyc;

   always #5 clk = ~clk;

   tt_sweep_capture_if ifa ();
   tt_sweep_capture_if ifb ();

   // dut_a models a function selected by mode_a; dut_b models y = (x == 31)
   assign ifa.y_in = (mode_a == 0) ? 1'b1 : ifa.x_out[0];
   assign ifb.y_in = (ifb.x_out == 5'd31);

   tt_sweep_capture #(.SETTLE_CYCLES(2), .EXPECTED(32'hAAAA_AAAA)) dut_a (
      .clk (clk),
      .rst (rst),
      .sw  (ifa.master)
   );

   tt_sweep_capture #(.SETTLE_CYCLES(0), .EXPECTED(32'h0000_0000)) dut_b (
      .clk (clk),
      .rst (rst),
      .sw  (ifb.master)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   // Returns edges from the start-accepting edge until done rises, or until rst_at.
   task automatic sweep(input int sel, input int restart_at, input int rst_at, output int cycles);
      @(negedge clk);
      if (sel == 0) ifa.start = 1'b1; else ifb.start = 1'b1;
      @(posedge clk);
      #1;
      ifa.start = 1'b0;
      ifb.start = 1'b0;
      chk("busy_on_start", (sel == 0) ? ifa.busy : ifb.busy, 1'b1);
      chk("done_cleared",  (sel == 0) ? ifa.done : ifb.done, 1'b0);
      cycles = 0;
      while (cycles < 400) begin
         @(posedge clk);
         cycles++;
         #1;
         if (cycles == rst_at) begin
            rst = 1'b0;
            return;
         end
         if (((sel == 0) ? ifa.done : ifb.done) === 1'b1) return;
         if (cycles == restart_at - 1) ifa.start = 1'b1;
         if (cycles == restart_at)     ifa.start = 1'b0;
         if (cycles == rst_at - 1)     rst = 1'b1;
      end
      chk("sweep_timeout", 32'(cycles), 32'd0);
   endtask

   initial begin
      ifa.start = 1'b0;
      ifb.start = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      chk("rst_x_out", 32'(ifa.x_out), 32'd0);
      chk("rst_busy", 32'(ifa.busy), 32'd0);
      chk("rst_done", 32'(ifa.done), 32'd0);
      chk("rst_table", ifa.table_out, 32'd0);
      chk("rst_ones", 32'(ifa.ones_count), 32'd0);
      chk("rst_match", 32'(ifa.match), 32'd0);
      chk("rst_b_done", 32'(ifb.done), 32'd0);

      mode_a = 0;
      sweep(0, -10, -10, cyc);
      chk("a1_cycles", 32'(cyc), 32'd96);
      chk("a1_busy", 32'(ifa.busy), 32'd0);
      chk("a1_table", ifa.table_out, 32'hFFFF_FFFF);
      chk("a1_ones", 32'(ifa.ones_count), 32'd32);
      chk("a1_match", 32'(ifa.match), 32'd0);
      chk("a1_x_hold", 32'(ifa.x_out), 32'd31);
`ifdef TT_MISMATCH_LOG_EN
      chk("a1_mm_valid", 32'(ifa.mismatch_valid), 32'd1);
      chk("a1_mm_idx", 32'(ifa.mismatch_idx), 32'd0);
`endif
      repeat (5) @(posedge clk);
      #1;
      chk("a1_done_sticky", 32'(ifa.done), 32'd1);

      mode_a = 1;
      sweep(0, -10, -10, cyc);
      chk("a2_cycles", 32'(cyc), 32'd96);
      chk("a2_table", ifa.table_out, 32'hAAAA_AAAA);
      chk("a2_ones", 32'(ifa.ones_count), 32'd16);
      chk("a2_match", 32'(ifa.match), 32'd1);
`ifdef TT_MISMATCH_LOG_EN
      chk("a2_mm_valid", 32'(ifa.mismatch_valid), 32'd0);
`endif

      mode_a = 0;
      sweep(0, 40, -10, cyc);
      chk("a3_restart_cycles", 32'(cyc), 32'd96);
      chk("a3_restart_table", ifa.table_out, 32'hFFFF_FFFF);
      chk("a3_restart_ones", 32'(ifa.ones_count), 32'd32);

      mode_a = 1;
      sweep(0, -10, 50, cyc);
      chk("a4_rst_cycle", 32'(cyc), 32'd50);
      chk("a4_rst_x_out", 32'(ifa.x_out), 32'd0);
      chk("a4_rst_busy", 32'(ifa.busy), 32'd0);
      chk("a4_rst_done", 32'(ifa.done), 32'd0);
      chk("a4_rst_table", ifa.table_out, 32'd0);
      chk("a4_rst_ones", 32'(ifa.ones_count), 32'd0);
      chk("a4_rst_match", 32'(ifa.match), 32'd0);
      sweep(0, -10, -10, cyc);
      chk("a4_cycles", 32'(cyc), 32'd96);
      chk("a4_table", ifa.table_out, 32'hAAAA_AAAA);
      chk("a4_match", 32'(ifa.match), 32'd1);

      sweep(1, -10, -10, cyc);
      chk("b_cycles", 32'(cyc), 32'd32);
      chk("b_table", ifb.table_out, 32'h8000_0000);
      chk("b_ones", 32'(ifb.ones_count), 32'd1);
      chk("b_match", 32'(ifb.match), 32'd0);
`ifdef TT_MISMATCH_LOG_EN
      chk("b_mm_valid", 32'(ifb.mismatch_valid), 32'd1);
      chk("b_mm_idx", 32'(ifb.mismatch_idx), 32'd31);
`endif

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule

// File: doc/tt_sweep_capture.md
Name: tt_sweep_capture

Overview:
- Exhaustive-sweep stage wrapped around the 5-input/1-output combinational function block.
- Upstream: drives the function's 5-bit input through all 32 vectors, 0 to 31 in order.
- Downstream: waits a programmable settle time per vector, samples the 1-bit output, and assembles a 32-bit truth table.
- Reports the one-count and a pass/fail compare against an expected table.
- Used on the board wrapper and in benches to sign off the combinational function.

Parameters:
SETTLE_CYCLES, 2, clock cycles x_out is held before y_in is sampled; legal range 0..15
EXPECTED, 32'h0000_0000, golden truth table; bit i = expected y for x = i

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
start  input  1  single-cycle request to begin a sweep
y_in  input  1  output of the function under test
x_out  output  5  vector driven to the function under test
busy  output  1  high while a sweep is in progress
done  output  1  sticky sweep-complete flag
table_out  output  32  captured truth table; bit i = sampled y for x = i
ones_count  output  6  number of 1s captured (0..32)
match  output  1  table_out == EXPECTED; valid when done=1

Behaviour:
- One clock; reset is synchronous and active-high on clk/rst.
- Reset values: state=IDLE, x_out=0, busy=0, done=0, table_out=0, ones_count=0, match=0, settle counter=0.
- States: IDLE, SETTLE, SAMPLE, DONE. All outputs are registered.
- IDLE, start=1:
  - clear table_out, ones_count, match and done; x_out=0; busy=1.
  - go to SETTLE if SETTLE_CYCLES>0, else SAMPLE.
- SETTLE:
  - hold x_out; count SETTLE_CYCLES cycles.
  - go to SAMPLE on the cycle the count reaches SETTLE_CYCLES-1.
- SAMPLE (1 cycle):
  - table_out[x_out] <= y_in; ones_count <= ones_count + y_in.
  - if x_out==31: go to DONE.
  - else: x_out <= x_out+1 and go to SETTLE (or SAMPLE if SETTLE_CYCLES=0).
- Entering DONE:
  - busy=0, done=1.
  - match <= (final table == EXPECTED), including the bit written in the last SAMPLE.
  - x_out holds 31.
- DONE:
  - outputs held indefinitely.
  - start=1 restarts exactly as from IDLE (clear, x_out=0, busy=1).
- Latency:
  - each vector occupies SETTLE_CYCLES+1 cycles.
  - done rises 32*(SETTLE_CYCLES+1) clocks after the edge that accepted start (96 at default).
- start while busy=1 is ignored; no restart, no effect on capture.
- Reset mid-sweep: next edge returns to the reset values above; the partial table is discarded.
- Arithmetic and widths:
  - x_out wraps never; the sweep terminates at 31.
  - ones_count is 6 bits, so 32 is representable without overflow.
- y_in is treated as synchronous to clk; no synchroniser inside the block.

Optional Feature:
- Macro: TT_MISMATCH_LOG_EN.
- When defined, two extra outputs are added:
  - mismatch_valid (1 bit)
  - mismatch_idx (5 bits)
- In each SAMPLE where y_in != EXPECTED[x_out] and mismatch_valid==0: mismatch_valid<=1 and mismatch_idx<=x_out. This records the first failing vector.
- Both outputs clear on reset and on an accepted start. Otherwise they hold their value, including in DONE.
- When not defined: no such ports or logic exist; all other behaviour is identical.

Test Plan:
- SETTLE_CYCLES=2, y_in tied 1, pulse start -> busy for 96 cycles; done at edge 96; table_out=32'hFFFF_FFFF, ones_count=32, match=0.
- y_in driven = x_out[0] by bench, EXPECTED=32'hAAAA_AAAA -> table_out=32'hAAAA_AAAA, ones_count=16, match=1.
- SETTLE_CYCLES=0, y_in = (x_out==5'd31) -> done after exactly 32 cycles; table_out=32'h8000_0000, ones_count=1.
- Start pulsed again at cycle 40 of a sweep -> ignored; done still at cycle 96; table unchanged versus the single-start run.
- rst asserted for one cycle at cycle 50 -> next cycle all outputs 0, state IDLE; a new start then completes a normal 96-cycle sweep.
- With TT_MISMATCH_LOG_EN, y_in = x_out[0], EXPECTED=32'hAAAA_AAAB -> match=0, mismatch_valid=1, mismatch_idx=0 (held through DONE).
